// File: rtl/cmd_dispatcher.sv
// Task dispatcher: forwards task packets to idle accelerators, tracks busy state,
// and retires it when an accelerator reports a finish packet on the reply stream.
module cmd_dispatcher #(
  parameter int          NUM_ACCS    = 16,
  parameter logic [7:0]  FINISH_CODE = 8'h03,
  localparam int         ACC_BITS    = (NUM_ACCS > 1) ? $clog2(NUM_ACCS) : 1
) (
  input  logic                clk,
  input  logic                rst,

  input  logic [63:0]         task_in_tdata,
  input  logic                task_in_tvalid,
  output logic                task_in_tready,
  input  logic                task_in_tlast,
  input  logic [ACC_BITS-1:0] task_in_tdest,

  output logic [63:0]         cmdin_tdata,
  output logic                cmdin_tvalid,
  input  logic                cmdin_tready,
  output logic                cmdin_tlast,
  output logic [ACC_BITS-1:0] cmdin_tdest,

  input  logic [63:0]         cmdout_tdata,
  input  logic                cmdout_tvalid,
  output logic                cmdout_tready,
  input  logic                cmdout_tlast,
  input  logic [ACC_BITS-1:0] cmdout_tid,
  input  logic [2:0]          cmdout_tdest,

  output logic [NUM_ACCS-1:0] busy,
  output logic [ACC_BITS:0]   outstanding,
  output logic                err_dest,
  output logic                err_spurious
);

  localparam logic [ACC_BITS:0] NUM_W = (ACC_BITS+1)'(NUM_ACCS);

  typedef enum logic [1:0] {IDLE, FWD, DROP} disp_state_t;
  typedef enum logic       {HDR, BODY}       cpl_state_t;

  disp_state_t          disp_state, disp_next;
  cpl_state_t           cpl_state,  cpl_next;
  logic [ACC_BITS-1:0]  dest_q, dest_d;
  logic [ACC_BITS-1:0]  tid_q, tid_d, clr_idx;
  logic                 armed_q, armed_d, hdr_arm, clr_fire, spurious;
  logic                 err_dest_d;
  logic [NUM_ACCS-1:0]  set_mask, clr_mask, busy_d;
  logic [ACC_BITS:0]    count_d;
  logic                 unused_bits;

  function automatic logic [NUM_ACCS-1:0] onehot(input logic [ACC_BITS-1:0] idx);
    logic [NUM_ACCS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_ACCS; i++) v[i] = (idx == ACC_BITS'(i));
    return v;
  endfunction

  assign cmdin_tdata   = task_in_tdata;
  assign cmdin_tlast   = task_in_tlast;
  assign cmdin_tdest   = dest_q;
  assign cmdout_tready = 1'b1;
  assign unused_bits   = &{1'b0, cmdout_tdest, cmdout_tdata[63:8]};

  always_comb begin
    disp_next      = disp_state;
    dest_d         = dest_q;
    err_dest_d     = err_dest;
    task_in_tready = 1'b0;
    cmdin_tvalid   = 1'b0;
    set_mask       = '0;
    case (disp_state)
      IDLE: begin
        if (task_in_tvalid) begin
          if ({1'b0, task_in_tdest} >= NUM_W) begin
            dest_d     = task_in_tdest;
            err_dest_d = 1'b1;
            disp_next  = DROP;
          end else if (!(|(busy & onehot(task_in_tdest)))) begin
            dest_d    = task_in_tdest;
            disp_next = FWD;
          end
        end
      end
      FWD: begin
        cmdin_tvalid   = task_in_tvalid;
        task_in_tready = cmdin_tready;
        if (task_in_tvalid && cmdin_tready && task_in_tlast) begin
          set_mask  = onehot(dest_q);
          disp_next = IDLE;
        end
      end
      DROP: begin
        task_in_tready = 1'b1;
        if (task_in_tvalid && task_in_tlast) disp_next = IDLE;
      end
      default: disp_next = IDLE;
    endcase
  end

  // Single-word finish packets arm and clear from the header itself, bypassing tid_q.
  always_comb begin
    cpl_next = cpl_state;
    tid_d    = tid_q;
    armed_d  = armed_q;
    clr_fire = 1'b0;
    clr_idx  = tid_q;
    hdr_arm  = (cmdout_tdata[7:0] == FINISH_CODE) && ({1'b0, cmdout_tid} < NUM_W);
    case (cpl_state)
      HDR: begin
        if (cmdout_tvalid) begin
          if (cmdout_tlast) begin
            clr_fire = hdr_arm;
            clr_idx  = cmdout_tid;
          end else begin
            cpl_next = BODY;
            tid_d    = cmdout_tid;
            armed_d  = hdr_arm;
          end
        end
      end
      BODY: begin
        if (cmdout_tvalid && cmdout_tlast) begin
          clr_fire = armed_q;
          cpl_next = HDR;
        end
      end
      default: cpl_next = HDR;
    endcase
  end

  always_comb begin
    clr_mask = clr_fire ? onehot(clr_idx) : '0;
    spurious = clr_fire && !(|(clr_mask & busy));
    busy_d   = (busy & ~clr_mask) | set_mask;
    count_d  = '0;
    for (int unsigned i = 0; i < NUM_ACCS; i++) count_d = count_d + (ACC_BITS+1)'(busy_d[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_state   <= IDLE;
      cpl_state    <= HDR;
      dest_q       <= '0;
      tid_q        <= '0;
      armed_q      <= 1'b0;
      busy         <= '0;
      outstanding  <= '0;
      err_dest     <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      disp_state   <= disp_next;
      cpl_state    <= cpl_next;
      dest_q       <= dest_d;
      tid_q        <= tid_d;
      armed_q      <= armed_d;
      busy         <= busy_d;
      outstanding  <= count_d;
      err_dest     <= err_dest_d;
      err_spurious <= err_spurious | spurious;
    end
  end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Bench for cmd_dispatcher: directed scenarios plus random traffic against a
// transaction-level model (expected-word queue, busy set, sticky error flags).
module tb_cmd_dispatcher;

  localparam int         NUM = 12;
  localparam int         AB  = 4;
  localparam logic [7:0] FIN = 8'h03;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   task_in_tdata;
  logic          task_in_tvalid, task_in_tready, task_in_tlast;
  logic [AB-1:0] task_in_tdest;
  logic [63:0]   cmdin_tdata;
  logic          cmdin_tvalid, cmdin_tready, cmdin_tlast;
  logic [AB-1:0] cmdin_tdest;
  logic [63:0]   cmdout_tdata;
  logic          cmdout_tvalid, cmdout_tready, cmdout_tlast;
  logic [AB-1:0] cmdout_tid;
  logic [2:0]    cmdout_tdest;
  logic [NUM-1:0] busy;
  logic [AB:0]   outstanding;
  logic          err_dest, err_spurious;

  cmd_dispatcher #(.NUM_ACCS(NUM), .FINISH_CODE(FIN)) dut (
    .clk(clk), .rst(rst),
    .task_in_tdata(task_in_tdata), .task_in_tvalid(task_in_tvalid), .task_in_tready(task_in_tready),
    .task_in_tlast(task_in_tlast), .task_in_tdest(task_in_tdest),
    .cmdin_tdata(cmdin_tdata), .cmdin_tvalid(cmdin_tvalid), .cmdin_tready(cmdin_tready),
    .cmdin_tlast(cmdin_tlast), .cmdin_tdest(cmdin_tdest),
    .cmdout_tdata(cmdout_tdata), .cmdout_tvalid(cmdout_tvalid), .cmdout_tready(cmdout_tready),
    .cmdout_tlast(cmdout_tlast), .cmdout_tid(cmdout_tid), .cmdout_tdest(cmdout_tdest),
    .busy(busy), .outstanding(outstanding), .err_dest(err_dest), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] d; logic l; logic [AB-1:0] dest; } word_t;
  word_t exp_q[$];

  logic [NUM-1:0] m_busy;
  logic           m_err_dest, m_err_spur;
  bit             rand_ready;
  int             n_checks = 0;
  int             n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    cmdin_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Every forwarded word must match the head of the expected queue, dest included while stalled.
  always @(negedge clk) begin
    word_t w;
    if (!rst && cmdin_tvalid) begin
      if (exp_q.size() == 0) check("cmdin_unexpected", 64'(cmdin_tvalid), 64'd0);
      else begin
        check("cmdin_tdest", 64'(cmdin_tdest), 64'(exp_q[0].dest));
        if (cmdin_tready) begin
          w = exp_q.pop_front();
          check("cmdin_tdata", cmdin_tdata, w.d);
          check("cmdin_tlast", 64'(cmdin_tlast), 64'(w.l));
        end
      end
    end
  end

  task automatic wait_hs(output int cnt);
    bit ok = 1'b0;
    cnt = 0;
    while (!ok && cnt < 60) begin
      @(negedge clk);
      cnt++;
      ok = task_in_tready;
    end
    if (!ok) check("task_hs_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_task(input logic [AB-1:0] dest, input int n, output int first_wait);
    word_t w;
    int    c;
    for (int i = 0; i < n; i++) begin
      task_in_tvalid = 1'b1;
      task_in_tdata  = {$urandom, $urandom};
      task_in_tlast  = (i == n - 1);
      task_in_tdest  = dest;
      if (dest < NUM) begin
        w.d = task_in_tdata; w.l = task_in_tlast; w.dest = dest;
        exp_q.push_back(w);
      end
      wait_hs(c);
      if (i == 0) first_wait = c;
    end
    task_in_tvalid = 1'b0;
    if (dest < NUM) m_busy[dest] = 1'b1;
    else m_err_dest = 1'b1;
  endtask

  task automatic send_reply(input logic [AB-1:0] tid, input logic [7:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      cmdout_tvalid = 1'b1;
      cmdout_tdata  = {$urandom, $urandom};
      if (i == 0) cmdout_tdata[7:0] = code;
      cmdout_tid    = (i == 0) ? tid : 4'($urandom);
      cmdout_tdest  = 3'($urandom);
      cmdout_tlast  = (i == n - 1);
      @(negedge clk);
      check("cmdout_tready", 64'(cmdout_tready), 64'd1);
      @(posedge clk); #1;
    end
    cmdout_tvalid = 1'b0;
    if (code == FIN && tid < NUM) begin
      if (m_busy[tid]) m_busy[tid] = 1'b0;
      else m_err_spur = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_busy"},        64'(busy),         64'(m_busy));
    check({tag, "_outstanding"}, 64'(outstanding),  64'($countones(m_busy)));
    check({tag, "_err_dest"},    64'(err_dest),     64'(m_err_dest));
    check({tag, "_err_spur"},    64'(err_spurious), 64'(m_err_spur));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},        64'(busy),           64'd0);
    check({tag, "_outstanding"}, 64'(outstanding),    64'd0);
    check({tag, "_err_dest"},    64'(err_dest),       64'd0);
    check({tag, "_err_spur"},    64'(err_spurious),   64'd0);
    check({tag, "_cmdin_tvalid"},64'(cmdin_tvalid),   64'd0);
    check({tag, "_task_tready"}, 64'(task_in_tready), 64'd0);
  endtask

  initial begin
    int fw, k, n;
    logic [AB-1:0] d;
    logic [7:0] code;

    rst = 1'b1; rand_ready = 1'b0; cmdin_tready = 1'b1;
    task_in_tvalid = 1'b0; task_in_tdata = '0; task_in_tlast = 1'b0; task_in_tdest = '0;
    cmdout_tvalid = 1'b0; cmdout_tdata = '0; cmdout_tlast = 1'b0; cmdout_tid = '0; cmdout_tdest = '0;
    m_busy = '0; m_err_dest = 1'b0; m_err_spur = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // 3-word task to accelerator 5
    send_task(4'd5, 3, fw);
    check("first_word_latency", 64'(fw), 64'd2);
    check_state("task5");
    check("busy_task5", 64'(busy), 64'h020);

    // second task to 5 stalls until a finish for 5 arrives
    fork
      send_task(4'd5, 2, fw);
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_tready", 64'(task_in_tready), 64'd0);
          check("stall_cmdin_tvalid", 64'(cmdin_tvalid), 64'd0);
        end
        @(posedge clk); #1;
        cmdout_tvalid = 1'b1; cmdout_tdata = 64'h0000_0000_0000_0003;
        cmdout_tid = 4'd5; cmdout_tlast = 1'b1;
        @(posedge clk); #1;
        cmdout_tvalid = 1'b0;
        m_busy[5] = 1'b0;
        k = 1;
        @(negedge clk);
        while (!cmdin_tvalid && k < 10) begin
          @(negedge clk);
          k++;
        end
        check("release_latency", 64'(k), 64'd2);
      end
    join
    check_state("restart5");

    // invalid destination is swallowed
    send_task(4'd14, 3, fw);
    check_state("bad_dest");

    // finish for an idle accelerator
    send_reply(4'd2, FIN, 1);
    check_state("spurious");

    // non-finish reply, out-of-range finish, multi-word finish
    send_reply(4'd5, 8'h44, 2);
    send_reply(4'd13, FIN, 2);
    check_state("no_effect");
    send_reply(4'd5, FIN, 3);
    check_state("multi_finish");

    // set of 3 and clear of 4 land on the same edge
    send_task(4'd4, 1, fw);
    fork
      send_task(4'd3, 1, fw);
      begin @(posedge clk); #1; send_reply(4'd4, FIN, 1); end
    join
    check_state("set_clr");

    // backpressured 4-word packets
    rand_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_task(4'd9, 4, fw);
      send_reply(4'd9, FIN, 1);
      check_state("bp");
    end

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        d = 4'($urandom_range(0, 15));
        n = $urandom_range(1, 4);
        if (d < NUM && m_busy[d]) send_reply(d, FIN, $urandom_range(1, 3));
        send_task(d, n, fw);
      end else begin
        d = 4'($urandom_range(0, 15));
        code = $urandom_range(0, 1) ? FIN : 8'($urandom);
        send_reply(d, code, $urandom_range(1, 3));
      end
      check_state("rnd");
    end

    // reset in the middle of a packet
    rand_ready = 1'b0;
    if (m_busy[7]) send_reply(4'd7, FIN, 1);
    task_in_tvalid = 1'b1; task_in_tdest = 4'd7; task_in_tlast = 1'b0;
    for (int i = 0; i < 2; i++) begin
      word_t w;
      task_in_tdata = {$urandom, $urandom};
      w.d = task_in_tdata; w.l = 1'b0; w.dest = 4'd7;
      exp_q.push_back(w);
      wait_hs(fw);
    end
    task_in_tdata = {$urandom, $urandom};
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset_outputs("mid_rst");
    m_busy = '0; m_err_dest = 1'b0; m_err_spur = 1'b0;
    @(posedge clk); #1;
    task_in_tvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_task(4'd7, 2, fw);
    check("post_rst_latency", 64'(fw), 64'd2);
    check_state("post_rst");

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
